// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, FSM states, fault codes
// and access-size decoding helpers (also used by writeback forwarding).
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_e;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

    function automatic logic isMemOp(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e opSize(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

    function automatic logic opSigned(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the memory.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a loaded word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (offset_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            BYTE:    result_o = {{24{signed_i & byteSel[7]}}, byteSel};
            HALF:    result_o = {{16{signed_i & halfSel[15]}}, halfSel};
            default: result_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack port, stalls upstream while
// an access is outstanding, and registers results into the MEM/WB register.
module memory_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           pcin,
    input  logic [31:0]           isnin,
    input  logic [31:0]           resultin,
    input  logic [31:0]           operandBin,
    input  logic                  validin,
    output logic [31:0]           pcout,
    output logic [31:0]           isnout,
    output logic [31:0]           resultout,
    output logic                  validout,
    output logic                  stall,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    memory_stage_if.master        dmem
);
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d, isn_q, isn_d, addr_q, addr_d, data_q, data_d;
    logic [31:0] pcout_q, pcout_d, isnout_q, isnout_d, resultout_q, resultout_d;
    logic        validout_q, validout_d, fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        stallC;

    logic [5:0]  opIn, opAcc;
    size_e       sizeIn, sizeAcc;
    logic        misaligned, signedAcc, storeAcc;
    logic [31:0] loadData;

    assign opIn       = isnin[31:26];
    assign opAcc      = isn_q[31:26];
    assign sizeIn     = opSize(opIn);
    assign sizeAcc    = opSize(opAcc);
    assign signedAcc  = opSigned(opAcc);
    assign storeAcc   = isStore(opAcc);
    assign misaligned = ((sizeIn == HALF) && resultin[0]) ||
                        ((sizeIn == WORD) && (resultin[1:0] != 2'b00));

    load_align uAlign (
        .rdata_i  (dmem.mem_rdata),
        .offset_i (addr_q[1:0]),
        .size_i   (sizeAcc),
        .signed_i (signedAcc),
        .result_o (loadData)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            isn_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            pcout_q     <= '0;
            isnout_q    <= '0;
            resultout_q <= '0;
            validout_q  <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            isn_q       <= isn_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pcout_q     <= pcout_d;
            isnout_q    <= isnout_d;
            resultout_q <= resultout_d;
            validout_q  <= validout_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    // Output registers hold their contents while an access is in flight; only validout clears.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        isn_d       = isn_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pcout_d     = pcout_q;
        isnout_d    = isnout_q;
        resultout_d = resultout_q;
        validout_d  = 1'b0;
        fault_d     = 1'b0;
        cause_d     = FAULT_NONE;
        stallC      = 1'b0;
        case (state_q)
            IDLE: begin
                if (validin && isMemOp(opIn) && !misaligned) begin
                    stallC  = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = '0;
                    pc_d    = pcin;
                    isn_d   = isnin;
                    addr_d  = resultin;
                    data_d  = operandBin;
                end else begin
                    pcout_d     = pcin;
                    isnout_d    = isnin;
                    resultout_d = resultin;
                    validout_d  = validin;
                    if (validin && isMemOp(opIn)) begin
                        fault_d = 1'b1;
                        cause_d = FAULT_MISALIGN;
                    end
                end
            end
            ACCESS: begin
                if (dmem.mem_ack) begin
                    state_d     = IDLE;
                    pcout_d     = pc_q;
                    isnout_d    = isn_q;
                    resultout_d = storeAcc ? addr_q : loadData;
                    validout_d  = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    pcout_d     = pc_q;
                    isnout_d    = isn_q;
                    resultout_d = '0;
                    validout_d  = 1'b1;
                    fault_d     = 1'b1;
                    cause_d     = FAULT_TIMEOUT;
                end else begin
                    stallC = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem.mem_req   = 1'b0;
        dmem.mem_we    = 1'b0;
        dmem.mem_addr  = '0;
        dmem.mem_wdata = '0;
        dmem.mem_be    = '0;
        if (state_q == ACCESS) begin
            dmem.mem_req  = 1'b1;
            dmem.mem_we   = storeAcc;
            dmem.mem_addr = {addr_q[31:2], 2'b00};
            case (sizeAcc)
                BYTE: begin
                    dmem.mem_wdata = {4{data_q[7:0]}};
                    dmem.mem_be    = storeAcc ? (4'b0001 << addr_q[1:0]) : 4'b1111;
                end
                HALF: begin
                    dmem.mem_wdata = {2{data_q[15:0]}};
                    dmem.mem_be    = (!storeAcc) ? 4'b1111 : (addr_q[1] ? 4'b1100 : 4'b0011);
                end
                default: begin
                    dmem.mem_wdata = data_q;
                    dmem.mem_be    = 4'b1111;
                end
            endcase
        end
    end

    // Gated by reset so upstream is released the moment reset asserts.
    assign stall       = reset & stallC;
    assign pcout       = pcout_q;
    assign isnout      = isnout_q;
    assign resultout   = resultout_q;
    assign validout    = validout_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table-driven transactions with a scoreboard
// on the MEM/WB outputs, plus a hand-written reset-during-access sequence.
module tb_memory_stage;
    logic        clock;
    logic        reset;
    logic [31:0] pcin, isnin, resultin, operandBin;
    logic        validin;
    logic [31:0] pcout, isnout, resultout;
    logic        validout, stall, fault;
    logic [1:0]  fault_cause;

    memory_stage_if dmem ();

    memory_stage #(.TIMEOUT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .pcin        (pcin),
        .isnin       (isnin),
        .resultin    (resultin),
        .operandBin  (operandBin),
        .validin     (validin),
        .pcout       (pcout),
        .isnout      (isnout),
        .resultout   (resultout),
        .validout    (validout),
        .stall       (stall),
        .fault       (fault),
        .fault_cause (fault_cause),
        .dmem        (dmem)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] b;
        logic        valid;
        logic [31:0] rdata;
        int          ackAt;
        int          expStall;
        logic        expReq;
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expResult;
        logic        expValid;
        logic        expFault;
        logic [1:0]  expCause;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] isn;
        logic [31:0] result;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];
    exp_t mon;
    int   checkCount = 0;
    int   passCount  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: every completed instruction must match the oldest pushed expectation.
    always @(negedge clock) begin
        if (reset && validout) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected validout: got pc 0x%08h expected nothing", pcout);
            end else begin
                mon = sbQ.pop_front();
                checkOutput("pcout", pcout, mon.pc);
                checkOutput("isnout", isnout, mon.isn);
                checkOutput("resultout", resultout, mon.result);
                checkOutput("fault", {31'b0, fault}, {31'b0, mon.fault});
                checkOutput("fault_cause", {30'b0, fault_cause}, {30'b0, mon.cause});
            end
        end else if (fault) begin
            checkCount++;
            $display("[TB] FAIL fault without validout: got 1 expected 0");
        end
    end

    function automatic vec_t mkVec(logic [5:0] op, logic [31:0] addr, logic [31:0] b, logic valid,
                                   logic [31:0] rdata, int ackAt, int expStall, logic expReq,
                                   logic expWe, logic [3:0] expBe, logic [31:0] expWdata,
                                   logic [31:0] expResult, logic expValid, logic expFault,
                                   logic [1:0] expCause);
        vec_t v;
        v.op = op; v.addr = addr; v.b = b; v.valid = valid; v.rdata = rdata;
        v.ackAt = ackAt; v.expStall = expStall; v.expReq = expReq; v.expWe = expWe;
        v.expBe = expBe; v.expWdata = expWdata; v.expResult = expResult;
        v.expValid = expValid; v.expFault = expFault; v.expCause = expCause;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        int   stallCycles = 0;
        int   accCycles   = 0;
        int   cyc         = 0;
        logic sawReq      = 1'b0;
        logic done        = 1'b0;
        logic [31:0] pc   = 32'h1000 + 32'(idx * 4);
        logic [31:0] isn  = {v.op, 26'(idx * 37 + 5)};
        exp_t e;
        pcin       = pc;
        isnin      = isn;
        resultin   = v.addr;
        operandBin = v.b;
        validin    = v.valid;
        if (v.expValid) begin
            e.pc = pc; e.isn = isn; e.result = v.expResult;
            e.fault = v.expFault; e.cause = v.expCause;
            sbQ.push_back(e);
        end
        while (!done) begin
            @(negedge clock);
            if (dmem.mem_req) begin
                accCycles++;
                if (!sawReq) begin
                    checkOutput($sformatf("v%0d mem_addr", idx), dmem.mem_addr, {v.addr[31:2], 2'b00});
                    checkOutput($sformatf("v%0d mem_be", idx), {28'b0, dmem.mem_be}, {28'b0, v.expBe});
                    checkOutput($sformatf("v%0d mem_we", idx), {31'b0, dmem.mem_we}, {31'b0, v.expWe});
                    if (v.expWe)
                        checkOutput($sformatf("v%0d mem_wdata", idx), dmem.mem_wdata, v.expWdata);
                end
                sawReq = 1'b1;
                if (accCycles == v.ackAt) begin
                    dmem.mem_ack   = 1'b1;
                    dmem.mem_rdata = v.rdata;
                end
            end
            #1;
            if (stall) stallCycles++;
            else done = 1'b1;
            @(posedge clock);
            #1;
            dmem.mem_ack   = 1'b0;
            dmem.mem_rdata = $urandom;
            cyc++;
            if (!done && cyc > 20) begin
                checkCount++;
                $display("[TB] FAIL v%0d stall bound: got stall after %0d cycles expected release", idx, cyc);
                done = 1'b1;
            end
        end
        checkOutput($sformatf("v%0d stall cycles", idx), 32'(stallCycles), 32'(v.expStall));
        checkOutput($sformatf("v%0d mem_req seen", idx), {31'b0, sawReq}, {31'b0, v.expReq});
    endtask

    initial begin
        reset = 1'b0;
        pcin = '0; isnin = '0; resultin = '0; operandBin = '0; validin = 1'b0;
        dmem.mem_ack = 1'b0; dmem.mem_rdata = '0;

        //            op     addr          b             v  rdata         ack st req we be       wdata         result        ev f  cause
        vecs.push_back(mkVec(6'h00, 32'h00001234, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00001234, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h00, 32'h00000055, 32'h0,        0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00000055, 0, 0, 2'b00));
        vecs.push_back(mkVec(6'h23, 32'h00000100, 32'h0,        1, 32'hDEADBEEF, 3, 3, 1, 0, 4'hF, 32'h0,        32'hDEADBEEF, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h20, 32'h00000103, 32'h0,        1, 32'h80000000, 1, 1, 1, 0, 4'hF, 32'h0,        32'hFFFFFF80, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h24, 32'h00000103, 32'h0,        1, 32'h80000000, 1, 1, 1, 0, 4'hF, 32'h0,        32'h00000080, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h29, 32'h00000102, 32'h0000ABCD, 1, 32'h0,        1, 1, 1, 1, 4'hC, 32'hABCDABCD, 32'h00000102, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h23, 32'h00000101, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00000101, 1, 1, 2'b01));
        vecs.push_back(mkVec(6'h23, 32'h00000200, 32'h0,        1, 32'h0,        0, 4, 1, 0, 4'hF, 32'h0,        32'h00000000, 1, 1, 2'b10));
        vecs.push_back(mkVec(6'h00, 32'h00000777, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00000777, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h21, 32'h00000202, 32'h0,        1, 32'h80017FFF, 2, 2, 1, 0, 4'hF, 32'h0,        32'hFFFF8001, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h25, 32'h00000200, 32'h0,        1, 32'h8001F00F, 1, 1, 1, 0, 4'hF, 32'h0,        32'h0000F00F, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h28, 32'h00000305, 32'h12345678, 1, 32'h0,        1, 1, 1, 1, 4'h2, 32'h78787878, 32'h00000305, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h2B, 32'h00000400, 32'hCAFEF00D, 1, 32'h0,        1, 1, 1, 1, 4'hF, 32'hCAFEF00D, 32'h00000400, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h21, 32'h00000101, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00000101, 1, 1, 2'b01));
        vecs.push_back(mkVec(6'h20, 32'h00000102, 32'h0,        1, 32'h007F0000, 1, 1, 1, 0, 4'hF, 32'h0,        32'h0000007F, 1, 0, 2'b00));
        vecs.push_back(mkVec(6'h23, 32'h00000101, 32'h0,        0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h00000101, 0, 0, 2'b00));
        vecs.push_back(mkVec(6'h3F, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'hFFFFFFFF, 1, 0, 2'b00));

        #12;
        checkOutput("reset validout", {31'b0, validout}, 32'h0);
        checkOutput("reset pcout", pcout, 32'h0);
        checkOutput("reset resultout", resultout, 32'h0);
        checkOutput("reset mem_req", {31'b0, dmem.mem_req}, 32'h0);
        checkOutput("reset stall", {31'b0, stall}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);
        validin = 1'b0;

        // Reset during an outstanding access, then a stray ack afterwards.
        pcin = 32'h5000; isnin = {6'h23, 26'h0}; resultin = 32'h500; validin = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("pre-reset mem_req", {31'b0, dmem.mem_req}, 32'h1);
        checkOutput("pre-reset stall", {31'b0, stall}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset mem_req", {31'b0, dmem.mem_req}, 32'h0);
        checkOutput("async reset stall", {31'b0, stall}, 32'h0);
        checkOutput("async reset validout", {31'b0, validout}, 32'h0);
        validin = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        dmem.mem_ack = 1'b1;
        dmem.mem_rdata = 32'h11223344;
        @(posedge clock); #1;
        dmem.mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checkOutput("stray ack validout", {31'b0, validout}, 32'h0);
            checkOutput("stray ack mem_req", {31'b0, dmem.mem_req}, 32'h0);
        end

        repeat (3) @(negedge clock);
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the execute/memory pipeline register.
- Consumes PC, instruction, ALU result (effective address) and operand B (store data).
- Performs byte/half/word loads and stores over a req/ack data-memory port and stalls upstream stages while an access is outstanding.
- Drives registered outputs into the memory/writeback pipeline register.

Parameters:
- TIMEOUT, 255: cycles spent in ACCESS without mem_ack before a timeout fault is raised (8-bit counter).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pcin  in  32  PC from the EX/MEM register
- isnin  in  32  instruction from the EX/MEM register
- resultin  in  32  ALU result / effective address
- operandBin  in  32  store data
- validin  in  1  EX/MEM contents are a real instruction
- pcout  out  32  PC to the MEM/WB register
- isnout  out  32  instruction to the MEM/WB register
- resultout  out  32  ALU result or formatted load data
- validout  out  1  outputs hold a completed instruction
- stall  out  1  combinational; upstream registers drive enable = !stall
- fault  out  1  one-cycle pulse aligned with validout
- fault_cause  out  2  01 = misaligned, 10 = timeout, 00 = none
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address {resultin[31:2],2'b00}
- mem_wdata  out  32  store data, replicated across byte lanes
- mem_be  out  4  byte enables
- mem_ack  in  1  access complete; rdata valid this cycle
- mem_rdata  in  32  load data word

Behaviour:
- Opcode is isnin[31:26]:
  - LB 20, LH 21, LBU 24, LHU 25, LW 23
  - SB 28, SH 29, SW 2B (hex)
  - All other opcodes are non-memory.
- Reset (async, active-low): state IDLE, counter 0, all outputs 0, mem_req drops immediately. An ack arriving after reset is ignored.
- States: IDLE, ACCESS.
- IDLE, non-memory or validin=0: at the next edge pcout/isnout/resultout take the inputs and validout takes validin. Latency 1. No stall.
- IDLE, memory op, misaligned (half with addr[0]=1; word with addr[1:0]!=0):
  - No request is issued and there is no stall.
  - Next edge: pass-through with validout=1, fault=1, fault_cause=01.
- IDLE, memory op, aligned:
  - stall=1 this cycle.
  - Capture pc, isn, address, data, op and byte offset.
  - Go to ACCESS; validout=0 next cycle.
- ACCESS:
  - mem_req=1 with stable addr/we/wdata/be.
  - stall = !mem_ack.
  - Counter increments each cycle without ack.
- ACCESS, on mem_ack:
  - Next edge: validout=1 and return to IDLE.
  - Load: resultout = formatted mem_rdata.
  - Store: resultout = captured address.
  - Minimum latency is 2 cycles, with ack in the first ACCESS cycle.
- ACCESS, counter reaching TIMEOUT before ack:
  - mem_req drops and the state returns to IDLE.
  - validout=1, resultout=0, fault=1, fault_cause=10.
  - stall drops in that cycle.
- Load formatting, with offset o = addr[1:0]:
  - Byte is rdata[8o+7:8o]; half is rdata[16(o>>1)+15:16(o>>1)].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- Byte enables:
  - SB: 1<<o.
  - SH: 0011 when o=0, 1100 when o=2.
  - SW: 1111.
  - Loads: 1111.
- wdata:
  - SB: {4{b[7:0]}}.
  - SH: {2{b[15:0]}}.
  - SW: b.
- mem_ack outside ACCESS is ignored.
- validin is sampled only in IDLE.
- fault is 0 whenever validout=0.

Decomposition:
- Shared package mem_pkg holds:
  - opcode constants
  - state enum
  - fault cause codes
  - access-size enum (BYTE/HALF/WORD)
- One combinational sub-module, load_align: (rdata, offset, size, signed) -> 32-bit result. It is reused by writeback forwarding.

Test Plan:
- ADD (opcode 00), resultin=0x1234 -> one cycle later resultout=0x1234, validout=1, stall never asserted.
- LW at addr 0x100, ack in the 3rd ACCESS cycle, rdata=0xDEADBEEF -> stall high for 3 cycles, mem_be=1111, resultout=0xDEADBEEF on the cycle after the ack.
- LB at addr 0x103 with rdata=0x80000000 -> resultout=0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- SH at addr 0x102, operandB=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
- LW at 0x101 -> no mem_req, no stall, next cycle fault=1 with cause 01. Separately, with no ack and TIMEOUT=4 -> fault cause 10 after 4 ACCESS cycles, then mem_req=0.
- Reset asserted mid-ACCESS -> mem_req, validout and stall drop asynchronously. A later ack produces no validout.
